lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute ALU. Takes the ALU result (effective address or plain
//  result), store data and access type; runs the data-memory request/grant/response handshake; aligns store data,
//  sign/zero-extends load data; hands one writeback beat per instruction to the register-file write port.
//  Non-memory ops pass through unchanged in one cycle.
// PARAMETERS
//  XLEN     32   datapath width; only 32 supported (4 byte lanes)
//  TIMEOUT  255  max cycles in REQ+WAIT before abort with error; 0 = no timeout; counter width 8 bits
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  ex_valid     in   1     execute stage presents an instruction
//  ex_ready     out  1     stage can accept (high only in IDLE)
//  ex_result    in   XLEN  ALU output: address for load/store, result otherwise
//  ex_wdata     in   XLEN  rs2 value for stores
//  ex_funct3    in   3     RISC-V funct3 of the instruction
//  ex_load      in   1     instruction is a load
//  ex_store     in   1     instruction is a store
//  ex_rd        in   5     destination register
//  dmem_req     out  1     memory request valid
//  dmem_we      out  1     1 = write
//  dmem_be      out  4     byte enables
//  dmem_addr    out  XLEN  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata   out  XLEN  lane-replicated store data
//  dmem_gnt     in   1     memory accepts request this cycle
//  dmem_rvalid  in   1     read data valid
//  dmem_rdata   in   XLEN  read data (full word)
//  wb_valid     out  1     one-cycle pulse: writeback beat
//  wb_we        out  1     write register file (0 for stores, errors, rd==0)
//  wb_rd        out  5     destination register
//  wb_data      out  XLEN  writeback value
//  wb_err       out  1     access error (misalign or timeout); qualified by wb_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all outputs 0 except ex_ready=1; timeout counter 0. Reset mid-transaction
//    abandons it; no wb_valid; dmem_rvalid arriving in IDLE is ignored.
//  - Accept on rising edge with ex_valid & ex_ready; ex_* captured into internal registers.
//  - States: IDLE -> (non-mem) RESP; (load|store, legal) REQ; (illegal/misaligned) RESP with err.
//    REQ: dmem_req=1, outputs stable until dmem_gnt; gnt&store -> RESP; gnt&load -> WAIT.
//    WAIT: dmem_rvalid -> RESP (rdata captured); rvalid only honoured in WAIT, never in the gnt cycle.
//    RESP: wb_valid=1 for exactly one cycle, then IDLE. Latency: non-mem 1 cycle; store 1+gnt wait;
//    load >=2 cycles after accept.
//  - Timeout: counter clears on entry to REQ, increments each REQ/WAIT cycle; reaching TIMEOUT -> RESP with
//    wb_err=1, wb_we=0, dmem_req dropped.
//  - Illegal: ex_load & ex_store both 1, load funct3 in {011,110,111}, store funct3 > 010 -> wb_err=1, wb_we=0,
//    no memory access.
//  - Byte lanes (a=addr[1:0]): byte be=4'b0001<<a, wdata={4{wdata[7:0]}}; half be=4'b0011<<{a[1],1'b0},
//    wdata={2{wdata[15:0]}}; word be=4'b1111.
//  - Load extraction: LB/LBU lane a, LH/LHU lane a[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW whole word.
//  - wb_we = ~err & ~store & (rd!=0); wb_data=0 for stores and errors; non-mem wb_data = ex_result.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a!=0 -> no request, RESP with wb_err=1, wb_we=0.
//  Not defined: low address bits force-aligned (half uses a[1] only, word ignores a); never errors on alignment.
// TESTING
//  1 non-mem: ex_result=0x1234_5678, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x1234_5678, no dmem_req.
//  2 SB addr=0x103, wdata=0xAB, gnt after 2 cycles -> dmem_be=4'b1000, dmem_addr=0x100, dmem_wdata=0xABABABAB,
//    req held 3 cycles, then wb_valid with wb_we=0.
//  3 LB addr=0x102, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; same with LBU -> 0x0000_0080; LHU addr 0x102,
//    rdata=0x8001_0000 -> 0x0000_8001.
//  4 LW rd=0 -> wb_valid=1, wb_we=0; LW with no rvalid and TIMEOUT=4 -> wb_err=1 after 4 cycles, req dropped.
//  5 LH addr=0x101: with MISALIGN_TRAP_EN -> no dmem_req, wb_err=1; without -> request addr 0x100, be=4'b0011.
//  6 rst_n low in WAIT, then rvalid -> no wb_valid, ex_ready=1, all outputs 0.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/grant/response bus between the LSU memory stage (master) and data memory (slave).
interface lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: data-memory handshake, store lane alignment, load extension, one writeback beat per op.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses report wb_err instead of being force-aligned.
//
//  state | meaning
//  IDLE  | ex_ready high, waiting for an instruction
//  REQ   | dmem_req held with stable bus until dmem_gnt
//  WAIT  | load granted, waiting for dmem_rvalid
//  RESP  | wb_valid pulse, back to IDLE next cycle
module lsu_mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [4:0]        ex_rd,
  lsu_mem_stage_if.master   dmem,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t          state;
  logic [7:0]      cnt;
  logic [2:0]      fn;
  logic [1:0]      a_q;
  logic [4:0]      rd_q;
  logic            store_q;

  logic [1:0]      a;
  logic            illegal;
  logic            misalign;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [7:0]      cnt_inc;
  logic            timeout_hit;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] load_data;

  assign a           = ex_result[1:0];
  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = TO_EN && (cnt_inc == TO_LIM);

  always_comb begin
    illegal = 1'b0;
    if (ex_load && ex_store)
      illegal = 1'b1;
    else if (ex_load && (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11))
      illegal = 1'b1;
    else if (ex_store && ex_funct3 > 3'b010)
      illegal = 1'b1;
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = (ex_load || ex_store) &&
                    ((ex_funct3[1:0] == 2'b01 && a[0]) || (ex_funct3[1:0] == 2'b10 && a != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Half accesses use a[1] only, so without the trap the low bit is simply dropped.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << a;
        wdata_next = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {a[1], 1'b0};
        wdata_next = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v    = dmem.rdata[{a_q, 3'b000} +: 8];
    half_v    = a_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    load_data = dmem.rdata;
    case (fn)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'd0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'd0, half_v};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ex_ready   <= 1'b1;
      cnt        <= 8'd0;
      fn         <= 3'd0;
      a_q        <= 2'd0;
      rd_q       <= 5'd0;
      store_q    <= 1'b0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.be    <= 4'd0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      wb_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            ex_ready <= 1'b0;
            fn       <= ex_funct3;
            a_q      <= a;
            rd_q     <= ex_rd;
            store_q  <= ex_store;
            if (illegal || misalign) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= ex_rd;
              wb_data  <= '0;
              wb_err   <= 1'b1;
            end else if (ex_load || ex_store) begin
              state      <= REQ;
              cnt        <= 8'd0;
              dmem.req   <= 1'b1;
              dmem.we    <= ex_store;
              dmem.be    <= be_next;
              dmem.addr  <= {ex_result[XLEN-1:2], 2'b00};
              dmem.wdata <= ex_store ? wdata_next : '0;
            end else begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
              wb_err   <= 1'b0;
            end
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (dmem.gnt || timeout_hit) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.be    <= 4'd0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
          end
          if (dmem.gnt) begin
            if (store_q) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= rd_q;
              wb_data  <= '0;
              wb_err   <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end else if (timeout_hit) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
            wb_data  <= '0;
            wb_err   <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (dmem.rvalid) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_we    <= (rd_q != 5'd0);
            wb_rd    <= rd_q;
            wb_data  <= load_data;
            wb_err   <= 1'b0;
          end else if (timeout_hit) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
            wb_data  <= '0;
            wb_err   <= 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          wb_rd    <= 5'd0;
          wb_data  <= '0;
          wb_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with TIMEOUT=4; expectations hand-computed per vector.
module tb_lsu_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_funct3;
  logic        ex_load;
  logic        ex_store;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_mem_stage_if dmem_bus ();

  lsu_mem_stage #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_result (ex_result),
    .ex_wdata  (ex_wdata),
    .ex_funct3 (ex_funct3),
    .ex_load   (ex_load),
    .ex_store  (ex_store),
    .ex_rd     (ex_rd),
    .dmem      (dmem_bus),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_load   = ld;
    ex_store  = st;
    ex_funct3 = f3;
    ex_result = res;
    ex_wdata  = wd;
    ex_rd     = rd;
    step();
    ex_valid  = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
  endtask

  // Immediate grant; a bogus rvalid in the grant cycle must be ignored.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata);
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    chk({tag, "_req"}, {31'd0, dmem_bus.req}, 32'd1);
    dmem_bus.gnt    = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'hDEAD_BEEF;
    step();
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    chk({tag, "_wait_nowb"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wait_noreq"}, {31'd0, dmem_bus.req}, 32'd0);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = rdata;
    step();
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_result = '0; ex_wdata = '0; ex_funct3 = '0;
    ex_load = 1'b0; ex_store = 1'b0; ex_rd = '0;
    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
    #12;
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_req", {31'd0, dmem_bus.req}, 32'd0);
    rst_n = 1'b1;
    step();

    // non-mem passthrough
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    chk("nm_wbv", {31'd0, wb_valid}, 32'd1);
    chk("nm_we", {31'd0, wb_we}, 32'd1);
    chk("nm_data", wb_data, 32'h1234_5678);
    chk("nm_rd", {27'd0, wb_rd}, 32'd5);
    chk("nm_req", {31'd0, dmem_bus.req}, 32'd0);
    chk("nm_ready", {31'd0, ex_ready}, 32'd0);
    step();
    chk("nm_wbv_pulse", {31'd0, wb_valid}, 32'd0);
    chk("nm_ready_back", {31'd0, ex_ready}, 32'd1);
    issue(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd0);
    chk("nm_rd0_we", {31'd0, wb_we}, 32'd0);
    step();

    // SB to 0x103, grant on third request cycle
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd9);
    chk("sb_req1", {31'd0, dmem_bus.req}, 32'd1);
    chk("sb_we", {31'd0, dmem_bus.we}, 32'd1);
    chk("sb_be", {28'd0, dmem_bus.be}, 32'h8);
    chk("sb_addr", dmem_bus.addr, 32'h0000_0100);
    chk("sb_wdata", dmem_bus.wdata, 32'hABAB_ABAB);
    step();
    chk("sb_req2", {31'd0, dmem_bus.req}, 32'd1);
    step();
    chk("sb_req3", {31'd0, dmem_bus.req}, 32'd1);
    chk("sb_be3", {28'd0, dmem_bus.be}, 32'h8);
    dmem_bus.gnt = 1'b1;
    step();
    dmem_bus.gnt = 1'b0;
    chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("sb_wbwe", {31'd0, wb_we}, 32'd0);
    chk("sb_wberr", {31'd0, wb_err}, 32'd0);
    chk("sb_req_off", {31'd0, dmem_bus.req}, 32'd0);
    step();

    // SH to 0x102 and SW to 0x108
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd1);
    chk("sh_be", {28'd0, dmem_bus.be}, 32'hC);
    chk("sh_wdata", dmem_bus.wdata, 32'hABCD_ABCD);
    dmem_bus.gnt = 1'b1; step(); dmem_bus.gnt = 1'b0;
    step();
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0108, 32'h1234_ABCD, 5'd1);
    chk("sw_be", {28'd0, dmem_bus.be}, 32'hF);
    chk("sw_wdata", dmem_bus.wdata, 32'h1234_ABCD);
    chk("sw_addr", dmem_bus.addr, 32'h0000_0108);
    dmem_bus.gnt = 1'b1; step(); dmem_bus.gnt = 1'b0;
    step();

    // loads
    do_load("lb", 3'b000, 32'h0000_0102, 5'd7, 32'h0080_0000);
    chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lb_we", {31'd0, wb_we}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_rd}, 32'd7);
    step();
    do_load("lbu", 3'b100, 32'h0000_0102, 5'd7, 32'h0080_0000);
    chk("lbu_data", wb_data, 32'h0000_0080);
    step();
    do_load("lhu", 3'b101, 32'h0000_0102, 5'd8, 32'h8001_0000);
    chk("lhu_data", wb_data, 32'h0000_8001);
    step();
    do_load("lh", 3'b001, 32'h0000_0102, 5'd8, 32'h8001_0000);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    step();
    do_load("lw0", 3'b010, 32'h0000_0104, 5'd0, 32'h1122_3344);
    chk("lw0_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lw0_we", {31'd0, wb_we}, 32'd0);
    chk("lw0_data", wb_data, 32'h1122_3344);
    step();

    // timeout with no grant: four REQ cycles, then error beat
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd3);
    step(); step(); step();
    chk("to_req4", {31'd0, dmem_bus.req}, 32'd1);
    chk("to_nowb4", {31'd0, wb_valid}, 32'd0);
    step();
    chk("to_wbv", {31'd0, wb_valid}, 32'd1);
    chk("to_err", {31'd0, wb_err}, 32'd1);
    chk("to_we", {31'd0, wb_we}, 32'd0);
    chk("to_req_off", {31'd0, dmem_bus.req}, 32'd0);
    step();

    // illegal encodings
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd2);
    chk("il_both_err", {31'd0, wb_err}, 32'd1);
    chk("il_both_req", {31'd0, dmem_bus.req}, 32'd0);
    step();
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd2);
    chk("il_ld_err", {31'd0, wb_err}, 32'd1);
    chk("il_ld_we", {31'd0, wb_we}, 32'd0);
    step();
    issue(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 5'd2);
    chk("il_st_err", {31'd0, wb_err}, 32'd1);
    chk("il_st_req", {31'd0, dmem_bus.req}, 32'd0);
    step();

    // LH at 0x101
`ifdef MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd4);
    chk("mis_req", {31'd0, dmem_bus.req}, 32'd0);
    chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
    chk("mis_err", {31'd0, wb_err}, 32'd1);
    chk("mis_we", {31'd0, wb_we}, 32'd0);
    step();
`else
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd4);
    chk("mis_req", {31'd0, dmem_bus.req}, 32'd1);
    chk("mis_addr", dmem_bus.addr, 32'h0000_0100);
    chk("mis_be", {28'd0, dmem_bus.be}, 32'h3);
    dmem_bus.gnt = 1'b1; step(); dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h0000_ABCD;
    step();
    dmem_bus.rvalid = 1'b0;
    chk("mis_data", wb_data, 32'hFFFF_ABCD);
    chk("mis_err", {31'd0, wb_err}, 32'd0);
    step();
`endif

    // reset while in WAIT, then a late rvalid
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd6);
    dmem_bus.gnt = 1'b1; step(); dmem_bus.gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rw_ready", {31'd0, ex_ready}, 32'd1);
    chk("rw_wbv", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h5555_AAAA;
    step();
    dmem_bus.rvalid = 1'b0;
    chk("rw_nowb", {31'd0, wb_valid}, 32'd0);
    chk("rw_ready2", {31'd0, ex_ready}, 32'd1);
    chk("rw_data", wb_data, 32'h0);
    chk("rw_req", {31'd0, dmem_bus.req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
